// File: rtl/mc_sequencer.sv
// Multicycle CPU control sequencer: walks the fetch/decode/execute/memory/
// writeback states, counts retired instructions, and stops on halt or on a
// memory-wait timeout.
module mc_sequencer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  input  logic        resume,
  output logic [2:0]  state,
  output logic        halted,
  output logic        instr_done,
  output logic        illegal_op,
  output logic        bus_err,
  output logic [31:0] instr_count
);

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_AEXE = 3'b110,
    S_BEXE = 3'b101,
    S_CEXE = 3'b010,
    S_MEM  = 3'b011,
    S_AWB  = 3'b111,
    S_CWB  = 3'b100
  } state_t;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);

  state_t     cur;
  logic [7:0] wait_cnt;
  // Remembers load vs store from ID, since opcode is only meaningful there.
  logic       is_load;

  assign state = cur;

  // Whole sequencer: state, flags, pulses and counters all registered together.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      cur         <= S_IF;
      halted      <= 1'b0;
      bus_err     <= 1'b0;
      instr_done  <= 1'b0;
      illegal_op  <= 1'b0;
      instr_count <= 32'd0;
      wait_cnt    <= 8'd0;
      is_load     <= 1'b0;
    end else begin
      // NOTE: pulses default low every cycle and are raised only by the
      // branch that fires them; non-blocking keeps later reads on old values.
      instr_done <= 1'b0;
      illegal_op <= 1'b0;

      unique case (cur)
        S_IF: begin
          if (halted) begin
            wait_cnt <= 8'd0;
            if (resume) halted <= 1'b0;
          end else if (mem_ready) begin
            cur      <= S_ID;
            wait_cnt <= 8'd0;
          end else if (wait_cnt >= TIMEOUT_W) begin
            bus_err  <= 1'b1;
            halted   <= 1'b1;
            wait_cnt <= 8'd0;
          end else if (wait_cnt != 8'hFF) begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        S_ID: begin
          wait_cnt <= 8'd0;
          case (opcode)
            OP_ADD, OP_SUB, OP_OR: cur <= S_AEXE;
            OP_BEQ:                cur <= S_BEXE;
            OP_SW, OP_LW: begin
              cur     <= S_CEXE;
              is_load <= (opcode == OP_LW);
            end
            OP_J: begin
              cur         <= S_IF;
              instr_done  <= 1'b1;
              instr_count <= instr_count + 32'd1;
            end
            OP_HALT: begin
              cur    <= S_IF;
              halted <= 1'b1;
            end
            default: begin
              cur        <= S_IF;
              illegal_op <= 1'b1;
            end
          endcase
        end

        S_AEXE: cur <= S_AWB;

        S_AWB, S_BEXE, S_CWB: begin
          cur         <= S_IF;
          instr_done  <= 1'b1;
          instr_count <= instr_count + 32'd1;
        end

        S_CEXE: cur <= S_MEM;

        S_MEM: begin
          if (mem_ready) begin
            wait_cnt <= 8'd0;
            if (is_load) begin
              cur <= S_CWB;
            end else begin
              cur         <= S_IF;
              instr_done  <= 1'b1;
              instr_count <= instr_count + 32'd1;
            end
          end else if (wait_cnt >= TIMEOUT_W) begin
            cur      <= S_IF;
            bus_err  <= 1'b1;
            halted   <= 1'b1;
            wait_cnt <= 8'd0;
          end else if (wait_cnt != 8'hFF) begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        default: cur <= S_IF;
      endcase
    end
  end

endmodule
